// File: rtl/alu_op_sequencer_if.sv
// Instruction-in / datapath-strobes-out bundle of the ALU op sequencer.
// Latency: none (signal grouping only).
// Backpressure: start is honoured only while ready is high; md_ready exists when MULDIV_STALL_EN is defined.
interface alu_op_sequencer_if #(
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 5
);
  // instruction side
  logic                 start;
  logic                 ready;
  logic [OP_W-1:0]      opcode;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
`ifdef MULDIV_STALL_EN
  logic                 md_ready;
`endif
  // datapath bus-control side
  logic                 reg_out_en;
  logic [REG_IDX_W-1:0] reg_out_sel;
  logic                 reg_in_en;
  logic [REG_IDX_W-1:0] reg_in_sel;
  logic                 c_out;
  logic                 y_in;
  logic                 z_in;
  logic                 zlo_out;
  logic                 zhi_out;
  logic                 lo_in;
  logic                 hi_in;
  logic [OP_W-1:0]      alu_op;
  logic                 done;
  logic                 illegal;

`ifdef MULDIV_STALL_EN
  modport master (
    output start, opcode, ra, rb, rc, md_ready,
    input  ready, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, c_out, y_in,
           z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, done, illegal
  );
  modport slave (
    input  start, opcode, ra, rb, rc, md_ready,
    output ready, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, c_out, y_in,
           z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, done, illegal
  );
`else
  modport master (
    output start, opcode, ra, rb, rc,
    input  ready, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, c_out, y_in,
           z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, done, illegal
  );
  modport slave (
    input  start, opcode, ra, rb, rc,
    output ready, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, c_out, y_in,
           z_in, zlo_out, zhi_out, lo_in, hi_in, alu_op, done, illegal
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps one decoded ALU-class instruction through T3..T6 register-transfer strobes.
// Latency: RR/IMM 3, MD 4, UN 2 cycles from accept to done; illegal opcodes pulse illegal 1 cycle after accept.
// Backpressure: ready is high only in IDLE; start elsewhere is ignored. MULDIV_STALL_EN adds md_ready, which holds MD in WAIT.
module alu_op_sequencer #(
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 5
) (
  input logic               clk,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T3, S_T4, S_T5, S_T6, S_ILL
`ifdef MULDIV_STALL_EN
    , S_WAIT
`endif
  } state_t;

  typedef enum logic [2:0] {C_RR, C_IMM, C_MD, C_UN, C_BAD} class_t;

  // Every registered control output except ready, grouped so reset and defaults are one assignment.
  typedef struct packed {
    logic                 reg_out_en;
    logic [REG_IDX_W-1:0] reg_out_sel;
    logic                 reg_in_en;
    logic [REG_IDX_W-1:0] reg_in_sel;
    logic                 c_out;
    logic                 y_in;
    logic                 z_in;
    logic                 zlo_out;
    logic                 zhi_out;
    logic                 lo_in;
    logic                 hi_in;
    logic [OP_W-1:0]      alu_op;
    logic                 done;
    logic                 illegal;
  } ctl_t;

  function automatic class_t f_class(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(3), OP_W'(4), OP_W'(5), OP_W'(6), OP_W'(7),
      OP_W'(8), OP_W'(9), OP_W'(10), OP_W'(11): f_class = C_RR;
      OP_W'(12), OP_W'(13), OP_W'(14):         f_class = C_IMM;
      OP_W'(15), OP_W'(16):                    f_class = C_MD;
      OP_W'(17), OP_W'(18):                    f_class = C_UN;
      default:                                 f_class = C_BAD;
    endcase
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [OP_W-1:0] f_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(12): f_alu_op = OP_W'(3);
      OP_W'(13): f_alu_op = OP_W'(5);
      OP_W'(14): f_alu_op = OP_W'(6);
      default:   f_alu_op = op;
    endcase
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  class_t               r_cls;
  logic [OP_W-1:0]      r_op;
  logic [REG_IDX_W-1:0] r_ra;
  logic [REG_IDX_W-1:0] r_rb;
  logic [REG_IDX_W-1:0] r_rc;

  class_t               w_cls;
  logic [OP_W-1:0]      w_op;
  logic [REG_IDX_W-1:0] w_ra;
  logic [REG_IDX_W-1:0] w_rb;
  logic [REG_IDX_W-1:0] w_rc;
  logic                 w_accept;

  ctl_t                 w_ctl;
  ctl_t                 r_ctl;
  logic                 r_ready;

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // State register; clear aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch the instruction fields on accept.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_cls <= C_RR;
      r_op  <= '0;
      r_ra  <= '0;
      r_rb  <= '0;
      r_rc  <= '0;
    end else if (w_accept) begin
      r_cls <= f_class(bus.opcode);
      r_op  <= bus.opcode;
      r_ra  <= bus.ra;
      r_rb  <= bus.rb;
      r_rc  <= bus.rc;
    end
  end

  // Next state plus the strobes of that next state, so the outputs can be registered with no extra cycle.
  always_comb begin
    // On the accept cycle the latches are not loaded yet, so look through to the inputs.
    w_cls = (r_state == S_IDLE) ? f_class(bus.opcode) : r_cls;
    w_op  = (r_state == S_IDLE) ? bus.opcode : r_op;
    w_ra  = (r_state == S_IDLE) ? bus.ra : r_ra;
    w_rb  = (r_state == S_IDLE) ? bus.rb : r_rb;
    w_rc  = (r_state == S_IDLE) ? bus.rc : r_rc;

    w_state_nxt = r_state;
    w_ctl       = '0;

    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = (w_cls == C_BAD) ? S_ILL : S_T3;
      S_T3:   w_state_nxt = S_T4;
      S_T4: begin
        if (w_cls == C_UN) w_state_nxt = S_IDLE;
`ifdef MULDIV_STALL_EN
        else if (w_cls == C_MD) w_state_nxt = S_WAIT;
`endif
        else w_state_nxt = S_T5;
      end
`ifdef MULDIV_STALL_EN
      S_WAIT: if (bus.md_ready) w_state_nxt = S_T5;
`endif
      S_T5:   w_state_nxt = (w_cls == C_MD) ? S_T6 : S_IDLE;
      S_T6:   w_state_nxt = S_IDLE;
      S_ILL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_T3: begin
        w_ctl.reg_out_en  = 1'b1;
        w_ctl.reg_out_sel = w_rb;
        if (w_cls == C_UN) begin
          w_ctl.alu_op = f_alu_op(w_op);
          w_ctl.z_in   = 1'b1;
        end else begin
          w_ctl.y_in   = 1'b1;
        end
      end
      S_T4: begin
        if (w_cls == C_UN) begin
          w_ctl.zlo_out    = 1'b1;
          w_ctl.reg_in_en  = 1'b1;
          w_ctl.reg_in_sel = w_ra;
          w_ctl.done       = 1'b1;
        end else begin
          if (w_cls == C_IMM) begin
            w_ctl.c_out       = 1'b1;
          end else begin
            w_ctl.reg_out_en  = 1'b1;
            w_ctl.reg_out_sel = w_rc;
          end
          w_ctl.alu_op = f_alu_op(w_op);
          w_ctl.z_in   = 1'b1;
        end
      end
      S_T5: begin
        w_ctl.zlo_out = 1'b1;
        if (w_cls == C_MD) begin
          w_ctl.lo_in      = 1'b1;
        end else begin
          w_ctl.reg_in_en  = 1'b1;
          w_ctl.reg_in_sel = w_ra;
          w_ctl.done       = 1'b1;
        end
      end
      S_T6: begin
        w_ctl.zhi_out = 1'b1;
        w_ctl.hi_in   = 1'b1;
        w_ctl.done    = 1'b1;
      end
      S_ILL:   w_ctl.illegal = 1'b1;
      default: w_ctl = '0;
    endcase
  end

  // Output register: strobes and ready change together with the state.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_ctl   <= '0;
      r_ready <= 1'b1;
    end else begin
      r_ctl   <= w_ctl;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign bus.ready       = r_ready;
  assign bus.reg_out_en  = r_ctl.reg_out_en;
  assign bus.reg_out_sel = r_ctl.reg_out_sel;
  assign bus.reg_in_en   = r_ctl.reg_in_en;
  assign bus.reg_in_sel  = r_ctl.reg_in_sel;
  assign bus.c_out       = r_ctl.c_out;
  assign bus.y_in        = r_ctl.y_in;
  assign bus.z_in        = r_ctl.z_in;
  assign bus.zlo_out     = r_ctl.zlo_out;
  assign bus.zhi_out     = r_ctl.zhi_out;
  assign bus.lo_in       = r_ctl.lo_in;
  assign bus.hi_in       = r_ctl.hi_in;
  assign bus.alu_op      = r_ctl.alu_op;
  assign bus.done        = r_ctl.done;
  assign bus.illegal     = r_ctl.illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer.
// Latency: checks accept-to-done / accept-to-illegal cycle counts per class.
// Backpressure: waits on ready before issuing; drives md_ready when MULDIV_STALL_EN is defined.
module tb_alu_op_sequencer;
  localparam int RW = 4;
  localparam int OW = 5;
`ifdef MULDIV_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef struct packed {
    logic          ready;
    logic          reg_out_en;
    logic [RW-1:0] reg_out_sel;
    logic          reg_in_en;
    logic [RW-1:0] reg_in_sel;
    logic          c_out;
    logic          y_in;
    logic          z_in;
    logic          zlo_out;
    logic          zhi_out;
    logic          lo_in;
    logic          hi_in;
    logic [OW-1:0] alu_op;
    logic          done;
    logic          illegal;
  } step_t;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.REG_IDX_W(RW), .OP_W(OW)) bus ();
  alu_op_sequencer #(.REG_IDX_W(RW), .OP_W(OW)) dut (.clk(clk), .clear(clear), .bus(bus));

  int    n_tests = 0;
  int    n_fail  = 0;
  step_t sb_q[$];
  bit    mon_en  = 1'b0;

  function automatic step_t sample();
    step_t s;
    s.ready       = bus.ready;
    s.reg_out_en  = bus.reg_out_en;
    s.reg_out_sel = bus.reg_out_sel;
    s.reg_in_en   = bus.reg_in_en;
    s.reg_in_sel  = bus.reg_in_sel;
    s.c_out       = bus.c_out;
    s.y_in        = bus.y_in;
    s.z_in        = bus.z_in;
    s.zlo_out     = bus.zlo_out;
    s.zhi_out     = bus.zhi_out;
    s.lo_in       = bus.lo_in;
    s.hi_in       = bus.hi_in;
    s.alu_op      = bus.alu_op;
    s.done        = bus.done;
    s.illegal     = bus.illegal;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: classes by opcode range, immediate forms map onto their register forms.
  function automatic int cls_of(input int op);
    if (op >= 3 && op <= 11)  return 0;  // RR
    if (op >= 12 && op <= 14) return 1;  // IMM
    if (op == 15 || op == 16) return 2;  // MD
    if (op == 17 || op == 18) return 3;  // UN
    return 4;
  endfunction

  function automatic int alu_of(input int op);
    if (op == 12) return 3;
    if (op == 13) return 5;
    if (op == 14) return 6;
    return op;
  endfunction

  // Build the expected non-empty steps, push the first 'keep' of them (all when keep<0), return the latency.
  task automatic push_model(input int op, input int ra, input int rb, input int rc,
                            input int w, input int keep, output int lat);
    step_t q[$];
    step_t s;
    int c = cls_of(op);
    if (c == 4) begin
      s = '0; s.illegal = 1; q.push_back(s);
    end else if (c == 3) begin
      s = '0; s.reg_out_en = 1; s.reg_out_sel = RW'(rb); s.alu_op = OW'(op); s.z_in = 1; q.push_back(s);
      s = '0; s.zlo_out = 1; s.reg_in_en = 1; s.reg_in_sel = RW'(ra); s.done = 1; q.push_back(s);
    end else begin
      s = '0; s.reg_out_en = 1; s.reg_out_sel = RW'(rb); s.y_in = 1; q.push_back(s);
      s = '0;
      if (c == 1) s.c_out = 1;
      else begin s.reg_out_en = 1; s.reg_out_sel = RW'(rc); end
      s.alu_op = OW'(alu_of(op)); s.z_in = 1; q.push_back(s);
      if (c == 2) begin
        s = '0; s.zlo_out = 1; s.lo_in = 1; q.push_back(s);
        s = '0; s.zhi_out = 1; s.hi_in = 1; s.done = 1; q.push_back(s);
      end else begin
        s = '0; s.zlo_out = 1; s.reg_in_en = 1; s.reg_in_sel = RW'(ra); s.done = 1; q.push_back(s);
      end
    end
    lat = q.size() + ((c == 2 && STALL) ? 1 + w : 0);
    for (int i = 0; i < q.size(); i++)
      if (keep < 0 || i < keep) sb_q.push_back(q[i]);
  endtask

  // Monitor: every cycle with any strobe active pops one expected step.
  always @(negedge clk) begin
    if (mon_en) begin
      step_t a;
      step_t e;
      a = sample();
      e = a; e.ready = 1'b0;
      if (e != '0) begin
        check("bus_onehot", ($countones({a.reg_out_en, a.c_out, a.zlo_out, a.zhi_out}) <= 1) ? 1 : 0, 1);
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: got %h, expected no activity", a);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL step: got %h, expected %h", a, e);
          end
        end
      end
    end
  end

  // mode 0: plain, 1: extra start during T4, 2: clear during T4.
  task automatic issue(input int op, input int ra, input int rb, input int rc, input int w, input int mode);
    int lat;
    int n;
    push_model(op, ra, rb, rc, w, (mode == 2) ? 2 : -1, lat);
    check("ready_before_start", bus.ready, 1);
    bus.start  = 1'b1;
    bus.opcode = OW'(op);
    bus.ra = RW'(ra); bus.rb = RW'(rb); bus.rc = RW'(rc);
`ifdef MULDIV_STALL_EN
    bus.md_ready = (cls_of(op) == 2) ? 1'b0 : 1'b1;
`endif
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.opcode = OW'($urandom); bus.ra = RW'($urandom); bus.rb = RW'($urandom); bus.rc = RW'($urandom);
    n = 1;
    while (n < 40 && !(bus.done || bus.illegal)) begin
      if (mode == 2 && n == 2) begin
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_ready", bus.ready, 1);
        check("clear_strobes_zero", (sample() == step_t'({1'b1, {($bits(step_t)-1){1'b0}}})) ? 1 : 0, 1);
        check("clear_sb_drained", sb_q.size(), 0);
        return;
      end
      if (mode == 1 && n == 2) begin
        bus.start = 1'b1; bus.opcode = OW'(5);
      end
`ifdef MULDIV_STALL_EN
      bus.md_ready = (n >= 3 + w) ? 1'b1 : 1'b0;
`endif
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
`ifdef MULDIV_STALL_EN
    bus.md_ready = 1'b1;
`endif
    check("latency", n, lat);
    @(posedge clk); #1;
    check("ready_after", bus.ready, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.opcode = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
`ifdef MULDIV_STALL_EN
    bus.md_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.ready, 1);
    check("reset_strobes_zero", (sample() == step_t'({1'b1, {($bits(step_t)-1){1'b0}}})) ? 1 : 0, 1);
    clear  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue(3, 3, 1, 2, 0, 0);      // add
    issue(12, 5, 4, 0, 0, 0);     // addi
    issue(13, 1, 2, 0, 0, 0);     // andi
    issue(14, 7, 8, 0, 0, 0);     // ori
    issue(16, 1, 6, 7, 0, 0);     // mul, md_ready ready at first WAIT
    issue(16, 1, 6, 7, 3, 0);     // mul, md_ready low for 3 WAIT cycles
    issue(15, 0, 3, 4, 1, 0);     // div, ra=0
    issue(17, 2, 9, 0, 0, 0);     // neg
    issue(18, 4, 5, 0, 0, 0);     // not
    issue(31, 1, 1, 1, 0, 0);     // illegal
    issue(0, 2, 2, 2, 0, 0);      // illegal
    issue(3, 6, 10, 11, 0, 1);    // add with start during T4
    issue(4, 6, 12, 13, 0, 2);    // sub aborted by clear during T4
    issue(9, 15, 14, 13, 0, 0);   // shr right after abort

    for (int i = 0; i < 60; i++)
      issue($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 3), 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
